// File: rtl/s1_fluxo_pontuacao.sv
// s1_fluxo_pontuacao
// Scoring/error datapath driven by the S1 game control FSM strobes.
// Owns the round counter L, the per-round error counter, a per-round
// error memory and the points register. At game end the FSM walks L
// over the memory, and each regPontos subtracts mem[L]*PENALIDADE from
// the score. The subtraction saturates at zero.
//
// Ports:
//   clock        : system clock (rising edge)
//   reset        : asynchronous, active-low clear of all state
//   zeraL/contaL : clear / increment L (saturates at NUM_RODADAS-1)
//   zeraErro/contaErro : clear / increment round error count (saturates at 15)
//   regErro      : mem[L] <= erros_rodada (pre-edge values)
//   zeraMemErro  : clear whole error memory
//   zeraPontos   : pontos <= PONTOS_INICIAIS
//   regPontos    : pontos <= sat(pontos - mem[L]*PENALIDADE)
//   fimL         : L == NUM_RODADAS-1 (combinational)
//   limite       : current L
//   erros_rodada : current round error count
//   erro_atual   : mem[L] (combinational read)
//   pontos       : points register
module s1_fluxo_pontuacao #(
  parameter int unsigned NUM_RODADAS     = 16,
  parameter int unsigned PONTOS_INICIAIS = 100,
  parameter int unsigned PENALIDADE      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraL,
  input  logic       contaL,
  input  logic       zeraErro,
  input  logic       contaErro,
  input  logic       regErro,
  input  logic       zeraMemErro,
  input  logic       zeraPontos,
  input  logic       regPontos,
  output logic       fimL,
  output logic [3:0] limite,
  output logic [3:0] erros_rodada,
  output logic [3:0] erro_atual,
  output logic [6:0] pontos
);

  localparam logic [3:0] L_MAX      = 4'(NUM_RODADAS - 1);
  localparam logic [6:0] PONTOS_INI = 7'(PONTOS_INICIAIS);
  localparam logic [6:0] PENAL      = 7'(PENALIDADE);

  logic [3:0] l_q, l_d;
  logic [3:0] erros_q, erros_d;
  logic [3:0] mem_q [NUM_RODADAS];
  logic [3:0] mem_d [NUM_RODADAS];
  logic [6:0] pontos_q, pontos_d;
  logic [6:0] penalidade;

  // Combinational read of the current round's entry; also feeds the penalty.
  assign erro_atual   = mem_q[l_q];
  assign fimL         = (l_q == L_MAX);
  assign limite       = l_q;
  assign erros_rodada = erros_q;
  assign pontos       = pontos_q;

  assign penalidade   = 7'(erro_atual) * PENAL;

  always_comb begin
    l_d = l_q;
    if (zeraL) begin
      l_d = '0;
    end else if (contaL && (l_q != L_MAX)) begin
      l_d = l_q + 4'd1;
    end
  end

  always_comb begin
    erros_d = erros_q;
    if (zeraErro) begin
      erros_d = '0;
    end else if (contaErro && (erros_q != 4'hF)) begin
      erros_d = erros_q + 4'd1;
    end
  end

  // regErro uses pre-edge L and erros_q, so same-cycle contaL/contaErro
  // only affect the following cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RODADAS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (zeraMemErro) begin
      for (int unsigned i = 0; i < NUM_RODADAS; i++) begin
        mem_d[i] = '0;
      end
    end else if (regErro) begin
      mem_d[l_q] = erros_q;
    end
  end

  always_comb begin
    pontos_d = pontos_q;
    if (zeraPontos) begin
      pontos_d = PONTOS_INI;
    end else if (regPontos) begin
      pontos_d = (pontos_q >= penalidade) ? (pontos_q - penalidade) : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l_q      <= '0;
      erros_q  <= '0;
      pontos_q <= PONTOS_INI;
      for (int unsigned i = 0; i < NUM_RODADAS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      l_q      <= l_d;
      erros_q  <= erros_d;
      pontos_q <= pontos_d;
      for (int unsigned i = 0; i < NUM_RODADAS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_s1_fluxo_pontuacao.sv
module tb_s1_fluxo_pontuacao;

  logic       clock;
  logic       reset;
  logic       zeraL, contaL, zeraErro, contaErro;
  logic       regErro, zeraMemErro, zeraPontos, regPontos;
  logic       fimL;
  logic [3:0] limite, erros_rodada, erro_atual;
  logic [6:0] pontos;

  int n_checks;
  int n_fail;

  s1_fluxo_pontuacao #(
    .NUM_RODADAS(16),
    .PONTOS_INICIAIS(100),
    .PENALIDADE(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .zeraL(zeraL),
    .contaL(contaL),
    .zeraErro(zeraErro),
    .contaErro(contaErro),
    .regErro(regErro),
    .zeraMemErro(zeraMemErro),
    .zeraPontos(zeraPontos),
    .regPontos(regPontos),
    .fimL(fimL),
    .limite(limite),
    .erros_rodada(erros_rodada),
    .erro_atual(erro_atual),
    .pontos(pontos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr_strobes();
    zeraL = 0; contaL = 0; zeraErro = 0; contaErro = 0;
    regErro = 0; zeraMemErro = 0; zeraPontos = 0; regPontos = 0;
  endtask

  // One active edge, then sample 1 time unit later; strobes dropped after.
  task automatic tick();
    @(posedge clock);
    #1;
    clr_strobes();
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (limite !== 4'd0) begin n_fail++; $display("FAIL reset_limite got %0d expected 0", limite); end
    n_checks++;
    if (pontos !== 7'd100) begin n_fail++; $display("FAIL reset_pontos got %0d expected 100", pontos); end
    // move state away from reset, then assert reset mid-cycle
    contaL = 1; contaErro = 1; regPontos = 1; tick();
    contaL = 1; contaErro = 1; regErro = 1; tick();
    #2;
    reset = 0;
    #1;
    n_checks++;
    if (limite !== 4'd0) begin n_fail++; $display("FAIL async_reset_limite got %0d expected 0", limite); end
    n_checks++;
    if (erros_rodada !== 4'd0) begin n_fail++; $display("FAIL async_reset_erros got %0d expected 0", erros_rodada); end
    n_checks++;
    if (pontos !== 7'd100) begin n_fail++; $display("FAIL async_reset_pontos got %0d expected 100", pontos); end
    n_checks++;
    if (fimL !== 1'b0) begin n_fail++; $display("FAIL async_reset_fimL got %0b expected 0", fimL); end
    n_checks++;
    if (erro_atual !== 4'd0) begin n_fail++; $display("FAIL async_reset_erro_atual got %0d expected 0", erro_atual); end
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  task automatic test_round_recording();
    for (int i = 0; i < 3; i++) begin contaErro = 1; tick(); end
    n_checks++;
    if (erros_rodada !== 4'd3) begin n_fail++; $display("FAIL rec_count got %0d expected 3", erros_rodada); end
    regErro = 1; tick();
    n_checks++;
    if (erro_atual !== 4'd3) begin n_fail++; $display("FAIL rec_mem0 got %0d expected 3", erro_atual); end
    zeraErro = 1; contaL = 1; tick();
    n_checks++;
    if (limite !== 4'd1) begin n_fail++; $display("FAIL rec_limite got %0d expected 1", limite); end
    n_checks++;
    if (erros_rodada !== 4'd0) begin n_fail++; $display("FAIL rec_erros_cleared got %0d expected 0", erros_rodada); end
    n_checks++;
    if (erro_atual !== 4'd0) begin n_fail++; $display("FAIL rec_mem1 got %0d expected 0", erro_atual); end
    zeraL = 1; tick();
    n_checks++;
    if (erro_atual !== 4'd3) begin n_fail++; $display("FAIL rec_mem0_reread got %0d expected 3", erro_atual); end
  endtask

  task automatic test_simultaneous();
    // L=0, mem[0]=3 on entry
    zeraErro = 1; tick();
    contaErro = 1; tick();
    contaErro = 1; tick();
    regErro = 1; contaErro = 1; tick();
    n_checks++;
    if (erro_atual !== 4'd2) begin n_fail++; $display("FAIL sim_reg_old_val got %0d expected 2", erro_atual); end
    n_checks++;
    if (erros_rodada !== 4'd3) begin n_fail++; $display("FAIL sim_count_after got %0d expected 3", erros_rodada); end
    // regErro with contaL writes at the old L
    regErro = 1; contaL = 1; tick();
    n_checks++;
    if (erro_atual !== 4'd0) begin n_fail++; $display("FAIL sim_new_L_untouched got %0d expected 0", erro_atual); end
    zeraL = 1; contaL = 1; tick();
    n_checks++;
    if (limite !== 4'd0) begin n_fail++; $display("FAIL sim_zeraL_prio got %0d expected 0", limite); end
    n_checks++;
    if (erro_atual !== 4'd3) begin n_fail++; $display("FAIL sim_reg_old_L got %0d expected 3", erro_atual); end
    zeraMemErro = 1; regErro = 1; tick();
    n_checks++;
    if (erro_atual !== 4'd0) begin n_fail++; $display("FAIL sim_zeraMem_prio got %0d expected 0", erro_atual); end
    zeraErro = 1; contaErro = 1; tick();
    n_checks++;
    if (erros_rodada !== 4'd0) begin n_fail++; $display("FAIL sim_zeraErro_prio got %0d expected 0", erros_rodada); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin contaErro = 1; tick(); end
    n_checks++;
    if (erros_rodada !== 4'd15) begin n_fail++; $display("FAIL sat_erros got %0d expected 15", erros_rodada); end
    zeraL = 1; tick();
    for (int i = 0; i < 14; i++) begin contaL = 1; tick(); end
    n_checks++;
    if (fimL !== 1'b0) begin n_fail++; $display("FAIL sat_fimL_at14 got %0b expected 0", fimL); end
    for (int i = 0; i < 5; i++) begin contaL = 1; tick(); end
    n_checks++;
    if (limite !== 4'd15) begin n_fail++; $display("FAIL sat_limite got %0d expected 15", limite); end
    n_checks++;
    if (fimL !== 1'b1) begin n_fail++; $display("FAIL sat_fimL got %0b expected 1", fimL); end
  endtask

  task automatic test_scoring_walk();
    int exp_p;
    do_reset();
    // mem = {3,0,1,0,...}
    for (int i = 0; i < 3; i++) begin contaErro = 1; tick(); end
    regErro = 1; tick();
    zeraErro = 1; contaL = 1; tick();
    regErro = 1; tick();
    contaL = 1; tick();
    contaErro = 1; tick();
    regErro = 1; tick();
    zeraL = 1; zeraPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd100) begin n_fail++; $display("FAIL walk_start got %0d expected 100", pontos); end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (fimL !== (i == 15)) begin n_fail++; $display("FAIL walk_fimL pos %0d got %0b expected %0b", i, fimL, (i == 15)); end
      regPontos = 1; tick();
      exp_p = (i < 2) ? 85 : 80;
      n_checks++;
      if (pontos !== 7'(exp_p)) begin n_fail++; $display("FAIL walk_pontos pos %0d got %0d expected %0d", i, pontos, exp_p); end
      contaL = 1; tick();
    end
  endtask

  task automatic test_back_to_back();
    // mem still {3,0,1,0,...}
    zeraL = 1; zeraPontos = 1; tick();
    regPontos = 1; contaL = 1; tick();
    n_checks++;
    if (pontos !== 7'd85) begin n_fail++; $display("FAIL b2b_pos0 got %0d expected 85", pontos); end
    regPontos = 1; contaL = 1; tick();
    n_checks++;
    if (pontos !== 7'd85) begin n_fail++; $display("FAIL b2b_pos1 got %0d expected 85", pontos); end
    n_checks++;
    if (limite !== 4'd2) begin n_fail++; $display("FAIL b2b_limite got %0d expected 2", limite); end
    regPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd80) begin n_fail++; $display("FAIL b2b_pos2 got %0d expected 80", pontos); end
    zeraPontos = 1; regPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd100) begin n_fail++; $display("FAIL b2b_zeraPontos_prio got %0d expected 100", pontos); end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin contaErro = 1; tick(); end
    regErro = 1; tick();
    contaL = 1; tick();
    regErro = 1; tick();
    zeraL = 1; zeraPontos = 1; tick();
    tick();
    regPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd25) begin n_fail++; $display("FAIL uf_pos0 got %0d expected 25", pontos); end
    contaL = 1; tick();
    tick();
    regPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd0) begin n_fail++; $display("FAIL uf_pos1 got %0d expected 0", pontos); end
    zeraL = 1; tick();
    regPontos = 1; tick();
    n_checks++;
    if (pontos !== 7'd0) begin n_fail++; $display("FAIL uf_stays0 got %0d expected 0", pontos); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 0;
    clr_strobes();
    test_reset();
    test_round_recording();
    test_simultaneous();
    test_saturation();
    test_scoring_walk();
    test_back_to_back();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s1_fluxo_pontuacao.md
# s1_fluxo_pontuacao

Scoring/error datapath that responds to the error and points strobes of the S1 game control FSM. It owns the round-limit counter L and the per-round error counter, records each round's error count into a small error memory, and scores the match at game end by walking that memory and subtracting a penalty per error from an initial score. It returns `fimL` to the FSM and drives the points value shown on the display.

## Interface
Parameters:
- `NUM_RODADAS`, default 16: rounds per game; L counts 0..NUM_RODADAS-1 (2..16 supported).
- `PONTOS_INICIAIS`, default 100: score loaded by `zeraPontos` and by reset; must be ≤127.
- `PENALIDADE`, default 5: points removed per recorded error.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `zeraL` in 1: clear L to 0.
- `contaL` in 1: increment L.
- `zeraErro` in 1: clear the round error counter.
- `contaErro` in 1: increment the round error counter.
- `regErro` in 1: write the round error counter into `mem[L]`.
- `zeraMemErro` in 1: clear all error-memory entries.
- `zeraPontos` in 1: load `PONTOS_INICIAIS` into the points register.
- `regPontos` in 1: points ← saturating (points − `mem[L]`·`PENALIDADE`).
- `fimL` out 1: L == NUM_RODADAS−1.
- `limite` out 4: current L.
- `erros_rodada` out 4: current round error count.
- `erro_atual` out 4: `mem[L]`, combinational read.
- `pontos` out 7: points register.

## Operation
- Strobes are one-cycle-wide level signals sampled on the rising edge, so each high cycle acts once. Strobes held high for k cycles act k times.
- **L counter:**
  - `zeraL` has priority over `contaL`.
  - `contaL` saturates at NUM_RODADAS−1 and does not wrap. `fimL` stays 1 once L is saturated.
- **Error counter:**
  - 4-bit, saturating at 15.
  - `zeraErro` has priority over `contaErro`.
- **Error memory:**
  - NUM_RODADAS × 4-bit registers.
  - `regErro` writes the pre-edge value of `erros_rodada` into `mem[L]`, using the pre-edge value of L. If `contaErro` or `contaL` is high in the same cycle, the write uses the old values.
  - `zeraMemErro` clears every entry in one cycle and has priority over a simultaneous `regErro`.
- **Points:**
  - Penalty = `mem[L]`·`PENALIDADE`, computed combinationally on 7 bits. The maximum is 15·5 = 75.
  - `regPontos`: if points ≥ penalty, points ← points − penalty; otherwise points ← 0. The result never underflows.
  - `zeraPontos` has priority over `regPontos`.
- **Scoring walk (sequence driven by the FSM):**
  - `zeraL` with `zeraPontos`, then per position a settle cycle followed by `regPontos` and then `contaL`, ending when `fimL` is seen at `regPontos`.
  - The block has no knowledge of this sequence. It only responds to the strobes.
- **Reset values** (reset low): L=0, `erros_rodada`=0, all `mem`=0, `pontos`=PONTOS_INICIAIS, and therefore `fimL`=0, `erro_atual`=0.
- A reset assertion in the middle of the scoring walk aborts it immediately. Nothing is retained.

## Timing
- `limite`, `erros_rodada`, and `pontos` are registered. Each updates on the edge where its strobe is high and is visible in the following cycle.
- `fimL` and `erro_atual` are combinational from L and the memory. They are valid in the same cycle as the L update, which gives the FSM a 0-cycle decision on `fimL` in `salva_pontos`.
- `erro_atual` reflects a `regErro` write in the cycle after the write edge.
- `regPontos` uses `mem[L]` with the L value present at that edge. A `contaL` in the same cycle does not affect the penalty applied.
- Reset deassertion is not synchronized inside the block. The FSM and this block share the same reset source.

## Test plan
- **Reset:** drive reset low mid-count → all outputs at their reset values within the same cycle; `pontos`=100.
- **Round recording:** 3× `contaErro`, then `regErro` at L=0, then `zeraErro` + `contaL` → `mem[0]`=3, `erros_rodada`=0, L=1.
- **Simultaneous strobes:**
  - With `erros_rodada`=2, assert `regErro`+`contaErro` together → `mem[L]`=2, `erros_rodada`=3.
  - Assert `zeraMemErro`+`regErro` together → `mem[L]`=0.
- **Saturation:**
  - 20× `contaErro` → 15.
  - NUM_RODADAS+3 × `contaL` → L=15, `fimL`=1.
- **Scoring walk:** with `mem`={3,0,1,0,…} (sum 4): `zeraL`+`zeraPontos`, then per position `regPontos` followed by `contaL` → final `pontos`=80, and `fimL`=1 at the last `regPontos`.
- **Underflow:** with `mem[0..1]`=15, run the walk → after position 0 `pontos`=25, after position 1 `pontos`=0, and it stays 0.
